// File: rtl/axi_burst_writer.sv
// axi_burst_writer: AXI4 write master that drains a FWFT FIFO into cfg_num_bursts INCR bursts.
// Ports: clk/rst (sync, active-high); start + cfg_base_addr/cfg_num_bursts launch a run;
// din/wr_en/full/ovf feed the FIFO; axi_aw*/axi_w*/axi_b* form the AXI4 write channels;
// busy/done/err report run status.
module axi_burst_writer #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 29,
  parameter int ID_W       = 4,
  parameter int BURST_LEN  = 100,
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_OUTST  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [CNT_W-1:0]    cfg_num_bursts,
  input  logic [DATA_W-1:0]   din,
  input  logic                wr_en,
  output logic                full,
  output logic                ovf,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [7:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic [ID_W-1:0]     axi_awid,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wlast,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [ID_W-1:0]     axi_bid,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [CNT_W-1:0] n, aw_cnt, w_cnt, b_cnt, b_nxt;
  logic [7:0] beat;
  logic [ADDR_W-1:0] addr;
  logic pop, push, drop, bid_unused;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  // data may only follow an address the slave has already accepted
  assign axi_wvalid = count != '0 && w_cnt < aw_cnt;
  assign pop = axi_wvalid && axi_wready;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && !push;
  assign axi_wdata = axi_wvalid ? mem[rd_ptr] : '0;
  assign axi_wstrb = {(DATA_W/8){axi_wvalid}};
  assign axi_wlast = axi_wvalid && beat == 8'(BURST_LEN - 1);
  assign axi_awaddr = axi_awvalid ? addr : '0;
  assign axi_awlen = axi_awvalid ? 8'(BURST_LEN - 1) : '0;
  assign axi_awsize = axi_awvalid ? 3'($clog2(DATA_W / 8)) : '0;
  assign axi_awburst = {1'b0, axi_awvalid};
  assign axi_awid = '0;
  assign axi_bready = 1'b1;
  assign busy = state == RUN;
  assign b_nxt = b_cnt + CNT_W'(axi_bvalid);
  assign bid_unused = ^axi_bid;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      count  <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      n           <= '0;
      aw_cnt      <= '0;
      w_cnt       <= '0;
      b_cnt       <= '0;
      beat        <= '0;
      addr        <= '0;
      axi_awvalid <= 1'b0;
      ovf         <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      ovf <= ovf | drop;
      if (pop) begin
        beat  <= axi_wlast ? '0 : beat + 8'd1;
        w_cnt <= w_cnt + CNT_W'(axi_wlast);
      end
      case (state)
        IDLE: if (start) begin
          state  <= cfg_num_bursts == '0 ? FIN : RUN;
          n      <= cfg_num_bursts;
          addr   <= cfg_base_addr;
          aw_cnt <= '0;
          w_cnt  <= '0;
          b_cnt  <= '0;
          ovf    <= drop;
          done   <= cfg_num_bursts == '0;
          err    <= 1'b0;
        end
        RUN: begin
          // the else-if keeps AWVALID low for at least one cycle after each handshake
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            aw_cnt      <= aw_cnt + 1'b1;
            addr        <= addr + BYTES;
          end else if (!axi_awvalid && aw_cnt < n && aw_cnt - b_cnt < CNT_W'(MAX_OUTST))
            axi_awvalid <= 1'b1;
          b_cnt <= b_nxt;
          err   <= err | (axi_bvalid && axi_bresp != 2'b00);
          if (b_nxt == n) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
